// File: rtl/qspi_sram_responder.sv
// qspi_sram_responder: SQI serial-SRAM target emulating a 23LC1024-style device.
// All logic runs on clk; sram_sck and sram_cs_n are oversampled through
// two-flop synchronisers. Inputs are taken on detected sck rises and outputs
// change on detected sck falls. MEM_ADDR_WIDTH must be at least 8.
module qspi_sram_responder #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter bit START_IN_QUAD  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sram_cs_n,
  input  logic                      sram_sck,
  input  logic                      sram_sio0_i,
  input  logic                      sram_sio1_i,
  input  logic                      sram_sio2_i,
  input  logic                      sram_sio3_i,
  output logic                      sram_sio0_o,
  output logic                      sram_sio1_o,
  output logic                      sram_sio2_o,
  output logic                      sram_sio3_o,
  output logic                      sram_sio_oe,
  output logic                      quad_mode,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]                dbg_data
);

  localparam int AW    = MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, Q_CMD, Q_ADDR, Q_DUMMY, Q_READ, Q_WRITE, IGNORE
  } state_t;

  // Handshake: none in the valid/ready sense. The link is strobe-based:
  // sio inputs are consumed only on a detected sck rise while cs_n is low,
  // and sio outputs change only on a detected sck fall in Q_READ.

  logic [7:0]    mem [DEPTH];

  logic [1:0]    cs_ff;
  logic [2:0]    sck_ff;
  logic [3:0]    sio_ff1, sio_ff2;

  logic          cs_s, sck_rise, sck_fall;
  logic [3:0]    nib;

  state_t        state;
  logic [2:0]    cnt;
  logic [6:0]    spi_sh;
  logic [AW-5:0] sh;
  logic          is_write;
  logic          half;
  logic [3:0]    hi_nib;
  logic [AW-1:0] addr;
  logic [3:0]    sio_o;
  logic          oe;
  logic          quad;

  logic [AW-1:0] addr_next;
  logic [7:0]    cmd_byte;
  logic [7:0]    spi_byte;
  logic [7:0]    rd_byte;
  logic          mem_we;
  logic [7:0]    mem_wdata;

  // Synchronise cs_n, sck and sio into the clk domain; sck keeps one extra stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_ff   <= 2'b11;
      sck_ff  <= 3'b000;
      sio_ff1 <= 4'h0;
      sio_ff2 <= 4'h0;
    end else begin
      cs_ff   <= {cs_ff[0], sram_cs_n};
      sck_ff  <= {sck_ff[1:0], sram_sck};
      sio_ff1 <= {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
      sio_ff2 <= sio_ff1;
    end
  end

  // Edge detection, shift-register views and memory write strobe
  always_comb begin
    cs_s      = cs_ff[1];
    sck_rise  = sck_ff[1] & ~sck_ff[2];
    sck_fall  = ~sck_ff[1] & sck_ff[2];
    nib       = sio_ff2;
    addr_next = {sh, nib};
    cmd_byte  = addr_next[7:0];
    spi_byte  = {spi_sh, nib[0]};
    rd_byte   = mem[addr];
    mem_we    = (state == Q_WRITE) && !cs_s && sck_rise && half;
    mem_wdata = {hi_nib, nib};
  end

  // Backing store: written on the low-nibble rise of each write byte, never reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  assign dbg_data = mem[dbg_addr];

  // Protocol FSM; cs_n high aborts any transaction and takes precedence over sck edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      spi_sh   <= '0;
      sh       <= '0;
      is_write <= 1'b0;
      half     <= 1'b0;
      hi_nib   <= 4'h0;
      addr     <= '0;
      sio_o    <= 4'h0;
      oe       <= 1'b0;
      quad     <= START_IN_QUAD;
    end else if (cs_s) begin
      state <= IDLE;
      oe    <= 1'b0;
      sio_o <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= 3'd0;
          half  <= 1'b0;
          state <= quad ? Q_CMD : SPI_CMD;
        end
        SPI_CMD: if (sck_rise) begin
          spi_sh <= spi_byte[6:0];
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (spi_byte == 8'h38) quad <= 1'b1;
            state <= IGNORE;
          end
        end
        Q_CMD: if (sck_rise) begin
          sh  <= addr_next[AW-5:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd1) begin
            cnt <= 3'd0;
            case (cmd_byte)
              8'h03: begin is_write <= 1'b0; state <= Q_ADDR; end
              8'h02: begin is_write <= 1'b1; state <= Q_ADDR; end
              8'hFF: begin quad <= 1'b0; state <= IGNORE; end
              default: state <= IGNORE;
            endcase
          end
        end
        Q_ADDR: if (sck_rise) begin
          sh  <= addr_next[AW-5:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            addr  <= addr_next;
            cnt   <= 3'd0;
            state <= is_write ? Q_WRITE : Q_DUMMY;
          end
        end
        Q_DUMMY: begin
          if (sck_rise && cnt < 3'd2) begin
            cnt <= cnt + 3'd1;
          end else if (sck_fall && cnt == 3'd2) begin
            oe    <= 1'b1;
            sio_o <= rd_byte[7:4];
            half  <= 1'b0;
            state <= Q_READ;
          end
        end
        Q_READ: if (sck_fall) begin
          if (!half) begin
            sio_o <= rd_byte[3:0];
            addr  <= addr + 1'b1;
            half  <= 1'b1;
          end else begin
            sio_o <= rd_byte[7:4];
            half  <= 1'b0;
          end
        end
        Q_WRITE: if (sck_rise) begin
          if (!half) begin
            hi_nib <= nib;
            half   <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
            half <= 1'b0;
          end
        end
        IGNORE: oe <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_sio0_o = sio_o[0];
  assign sram_sio1_o = sio_o[1];
  assign sram_sio2_o = sio_o[2];
  assign sram_sio3_o = sio_o[3];
  assign sram_sio_oe = oe;
  assign quad_mode   = quad;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Self-checking bench for qspi_sram_responder: table of write/read transactions,
// expected read nibbles queued at drive time and compared as they arrive,
// plus hand-written abort, mode-switch and reset sequences.
module tb_qspi_sram_responder;

  localparam int H = 8;  // clk periods per sck phase

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n, sck;
  logic [3:0] sio_i;
  logic       sio0_o, sio1_o, sio2_o, sio3_o;
  logic       oe, quad;
  logic [9:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  qspi_sram_responder #(.MEM_ADDR_WIDTH(10), .START_IN_QUAD(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .sram_cs_n(cs_n), .sram_sck(sck),
    .sram_sio0_i(sio_i[0]), .sram_sio1_i(sio_i[1]),
    .sram_sio2_i(sio_i[2]), .sram_sio3_i(sio_i[3]),
    .sram_sio0_o(sio0_o), .sram_sio1_o(sio1_o),
    .sram_sio2_o(sio2_o), .sram_sio3_o(sio3_o),
    .sram_sio_oe(oe), .quad_mode(quad),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  wire [3:0] sio_o = {sio3_o, sio2_o, sio1_o, sio0_o};

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int oe_bad = 0;
  logic oe_window = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // sio_oe must only be seen while a read data phase is in progress
  always @(negedge clk) if (oe === 1'b1 && !oe_window) oe_bad++;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit expired");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    clk_wait(H);
  endtask

  task automatic cs_finish();
    clk_wait(H);
    cs_n = 1'b1;
    clk_wait(2 * H);
    oe_window = 1'b0;
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic oe_s);
    sio_i = d;
    clk_wait(H);
    sck = 1'b1;
    @(negedge clk);
    q    = sio_o;
    oe_s = oe;
    clk_wait(H);
    sck = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] d);
    logic [3:0] q;
    logic       o;
    sck_cycle(d, q, o);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    cs_begin();
    for (int i = 7; i >= 0; i--) send_nib({3'b000, b[i]});
    cs_finish();
  endtask

  task automatic q_header(input logic [7:0] cmd, input logic [23:0] a);
    send_byte(cmd);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic q_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    cs_begin();
    q_header(8'h02, a);
    send_byte(d0);
    send_byte(d1);
    cs_finish();
  endtask

  // Dummy phase and then data until the expected queue drains
  task automatic q_read_data();
    logic [3:0] q, e;
    logic       o;
    for (int i = 0; i < 2; i++) begin
      sck_cycle(4'h0, q, o);
      check("dummy_oe_low", o, 1'b0);
    end
    oe_window = 1'b1;
    while (exp_q.size() > 0) begin
      sck_cycle(4'h0, q, o);
      e = exp_q.pop_front();
      check("read_nibble", q, e);
      check("read_oe_high", o, 1'b1);
    end
  endtask

  task automatic q_read(input logic [23:0] a, input logic [7:0] e0, input logic [7:0] e1);
    exp_q.push_back(e0[7:4]);
    exp_q.push_back(e0[3:0]);
    exp_q.push_back(e1[7:4]);
    exp_q.push_back(e1[3:0]);
    cs_begin();
    q_header(8'h03, a);
    q_read_data();
    cs_finish();
    check("oe_after_cs_high", oe, 1'b0);
  endtask

  task automatic dbg_check(input logic [9:0] a, input logic [7:0] e);
    dbg_addr = a;
    @(negedge clk);
    check("dbg_mem", dbg_data, e);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [7:0]  d0, d1;  // write data
    logic [9:0]  a0, a1;  // backdoor addresses checked after a write
    logic [7:0]  e0, e1;  // expected backdoor bytes (write) or read bytes (read)
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 24'h000010, 8'hA5, 8'h3C, 10'h010, 10'h011, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 24'h000010, 8'h00, 8'h00, 10'h000, 10'h000, 8'hA5, 8'h3C};
    vecs[2] = '{1'b1, 24'h0003FF, 8'h11, 8'h22, 10'h3FF, 10'h000, 8'h11, 8'h22};
    vecs[3] = '{1'b0, 24'h0003FF, 8'h00, 8'h00, 10'h000, 10'h000, 8'h11, 8'h22};
    vecs[4] = '{1'b1, 24'h000100, 8'h5A, 8'hC3, 10'h100, 10'h101, 8'h5A, 8'hC3};
    vecs[5] = '{1'b0, 24'hABC100, 8'h00, 8'h00, 10'h000, 10'h000, 8'h5A, 8'hC3};
    vecs[6] = '{1'b1, 24'h000020, 8'h99, 8'h77, 10'h020, 10'h021, 8'h99, 8'h77};

    reset_n  = 1'b0;
    cs_n     = 1'b1;
    sck      = 1'b0;
    sio_i    = 4'h0;
    dbg_addr = 10'h0;
    clk_wait(4);
    @(negedge clk);
    check("reset_oe", oe, 1'b0);
    check("reset_quad", quad, 1'b0);
    check("reset_sio", sio_o, 4'h0);
    reset_n = 1'b1;
    clk_wait(4);

    // SPI-mode non-quad command leaves mode alone, 0x38 enters SQI
    spi_cmd(8'h03);
    check("spi_other_quad", quad, 1'b0);
    spi_cmd(8'h38);
    check("spi_38_quad", quad, 1'b1);
    check("spi_no_oe", oe_bad, 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) begin
        q_write(vecs[i].addr, vecs[i].d0, vecs[i].d1);
        dbg_check(vecs[i].a0, vecs[i].e0);
        dbg_check(vecs[i].a1, vecs[i].e1);
      end else begin
        q_read(vecs[i].addr, vecs[i].e0, vecs[i].e1);
      end
    end

    // Abort mid-byte: a lone high nibble must not reach memory
    cs_begin();
    q_header(8'h02, 24'h000020);
    send_nib(4'h7);
    cs_finish();
    dbg_check(10'h020, 8'h99);
    q_read(24'h000020, 8'h99, 8'h77);

    // Unknown quad command is ignored: no write happens, no drive
    cs_begin();
    send_byte(8'h5A);
    for (int i = 0; i < 8; i++) send_nib(4'hE);
    cs_finish();
    dbg_check(10'h010, 8'hA5);
    check("unknown_cmd_quad", quad, 1'b1);

    // 0xFF leaves SQI mode
    cs_begin();
    send_byte(8'hFF);
    cs_finish();
    check("ff_quad", quad, 1'b0);

    // Back to SQI, then reset in the middle of a read
    spi_cmd(8'h38);
    check("spi_38_again", quad, 1'b1);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h5);
    cs_begin();
    q_header(8'h03, 24'h000010);
    q_read_data();
    clk_wait(4);
    check("mid_read_oe", oe, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("reset_oe_immediate", oe, 1'b0);
    check("reset_sio_immediate", sio_o, 4'h0);
    oe_window = 1'b0;
    cs_n = 1'b1;
    sck  = 1'b0;
    clk_wait(4);
    reset_n = 1'b1;
    clk_wait(4);
    @(negedge clk);
    check("post_reset_quad", quad, 1'b0);
    check("oe_outside_read", oe_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
